// File: rtl/cnn_pkg.sv
// ============================================================================
// Module   : cnn_pkg
// Purpose  : Shared constants for the CNN processing core and its output buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cnn_pkg;

    // Core result latency: sram 1 + mult 5 + acc 4
    localparam int CORE_RES_LATENCY = 10;
    localparam int FP_WIDTH         = 32;

    localparam int OUTBUF_DEPTH     = 32;
    localparam int OUTBUF_SLACK     = 12;

endpackage : cnn_pkg

`default_nettype wire

// File: rtl/outbuf_mem.sv
// ============================================================================
// Module   : outbuf_mem
// Purpose  : DEPTH x DWIDTH register array, one write port, asynchronous read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module outbuf_mem #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 32,
    parameter int AW     = 5
) (
    input  logic              clock,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DWIDTH-1:0] rdata_o
);

    logic [DWIDTH-1:0] mem_q [DEPTH];

    // Contents are not reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : outbuf_mem

`default_nettype wire

// File: rtl/proc_outbuf.sv
// ============================================================================
// Module   : proc_outbuf
// Purpose  : FWFT result buffer behind the processing core with early stall
//            generation and a sticky overflow flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module proc_outbuf
    import cnn_pkg::*;
#(
    parameter int DWIDTH = FP_WIDTH,
    parameter int DEPTH  = OUTBUF_DEPTH,
    parameter int SLACK  = OUTBUF_SLACK
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [DWIDTH-1:0]          accres_i,
    input  logic                       accresvalid_i,
    input  logic                       hold_i,
    output logic                       stall_o,
    output logic [DWIDTH-1:0]          out_data_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       ovf_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_THR = CW'(DEPTH - SLACK);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;
    logic              ovf_q,    ovf_d;

    logic              stall;
    logic              push_req;
    logic              pop;
    logic              push;
    logic              drop;
    logic [DWIDTH-1:0] rd_data;

    // SLACK=0 means no reserved headroom: the buffer never back-pressures the core.
    assign stall = (SLACK != 0) && (count_q >= STALL_THR);

    always_comb begin
        push_req = accresvalid_i & ~stall & ~hold_i;
        pop      = (count_q != '0) & out_ready_i;
        push     = push_req & ((count_q != FULL_CNT) | pop);
        drop     = push_req & (count_q == FULL_CNT) & ~pop;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        ovf_d    = ovf_q | drop;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    outbuf_mem #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clock   (clock),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (accres_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    // Masking with valid keeps the output at zero after reset despite stale storage.
    assign out_valid_o = (count_q != '0);
    assign out_data_o  = out_valid_o ? rd_data : '0;
    assign stall_o     = stall;
    assign count_o     = count_q;
    assign ovf_o       = ovf_q;

    generate
        if (SLACK >= CORE_RES_LATENCY + 2) begin : g_ovf_chk
            a_no_ovf: assert property (@(posedge clock) disable iff (reset) !ovf_q);
        end
    endgenerate

endmodule : proc_outbuf

`default_nettype wire

// File: tb/tb_proc_outbuf.sv
// ============================================================================
// Module   : tb_proc_outbuf
// Purpose  : Self-checking bench for proc_outbuf (default and SLACK=0 instances).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_proc_outbuf;
    import cnn_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int CW    = $clog2(DEPTH+1);
    localparam int THR_A = DEPTH - 12;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic [DW-1:0] a_d = '0, b_d = '0;
    logic a_v = 0, a_h = 0, a_r = 0;
    logic b_v = 0, b_h = 0, b_r = 0;
    logic a_stall, a_valid, a_ovf, b_stall, b_valid, b_ovf;
    logic [DW-1:0] a_data, b_data;
    logic [CW-1:0] a_count, b_count;

    proc_outbuf #(.DWIDTH(DW), .DEPTH(DEPTH), .SLACK(12)) dut_a (
        .clock(clock), .reset(reset), .accres_i(a_d), .accresvalid_i(a_v),
        .hold_i(a_h), .stall_o(a_stall), .out_data_o(a_data), .out_valid_o(a_valid),
        .out_ready_i(a_r), .count_o(a_count), .ovf_o(a_ovf));

    proc_outbuf #(.DWIDTH(DW), .DEPTH(DEPTH), .SLACK(0)) dut_b (
        .clock(clock), .reset(reset), .accres_i(b_d), .accresvalid_i(b_v),
        .hold_i(b_h), .stall_o(b_stall), .out_data_o(b_data), .out_valid_o(b_valid),
        .out_ready_i(b_r), .count_o(b_count), .ovf_o(b_ovf));

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Behavioural model: a plain queue per instance, pop first so a full
    // buffer with a simultaneous pop still accepts the new word.
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    bit ovfa = 0, ovfb = 0;
    int pushes_a = 0;
    bit pra, prb;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            qa.delete(); qb.delete();
            ovfa = 0; ovfb = 0;
        end else begin
            pra = a_v && !(qa.size() >= THR_A) && !a_h;
            if (qa.size() != 0 && a_r) void'(qa.pop_front());
            if (pra) begin
                if (qa.size() < DEPTH) begin qa.push_back(a_d); pushes_a++; end
                else ovfa = 1;
            end
            prb = b_v && !b_h;
            if (qb.size() != 0 && b_r) void'(qb.pop_front());
            if (prb) begin
                if (qb.size() < DEPTH) qb.push_back(b_d);
                else ovfb = 1;
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            chk("a_count", 32'(a_count), qa.size());
            chk("a_valid", 32'(a_valid), 32'(qa.size() != 0));
            chk("a_data",  a_data, (qa.size() != 0) ? qa[0] : 32'h0);
            chk("a_stall", 32'(a_stall), 32'(qa.size() >= THR_A));
            chk("a_ovf",   32'(a_ovf), 32'(ovfa));
            chk("b_count", 32'(b_count), qb.size());
            chk("b_data",  b_data, (qb.size() != 0) ? qb[0] : 32'h0);
            chk("b_ovf",   32'(b_ovf), 32'(ovfb));
        end
    end

    logic          pv [10];
    logic [DW-1:0] pd [10];
    int seq = 0;
    int p0;
    logic st;

    initial begin
        repeat (2) @(negedge clock);
        reset = 0;
        tick();

        // Reset mid-stream
        a_r = 0; a_v = 1;
        for (int i = 0; i < 5; i++) begin a_d = 32'hA000_0000 + 32'(i); tick(); end
        a_v = 0;
        chk("t1_count5", 32'(a_count), 5);
        #2 reset = 1;
        #1;
        chk("t1_rst_count", 32'(a_count), 0);
        chk("t1_rst_valid", 32'(a_valid), 0);
        chk("t1_rst_ovf",   32'(a_ovf), 0);
        chk("t1_rst_stall", 32'(a_stall), 0);
        chk("t1_rst_data",  a_data, 0);
        @(negedge clock);
        reset = 0;
        tick();
        a_v = 1; a_d = 32'h3F80_0000;
        tick();
        a_d = 32'h4000_0000;
        chk("t1_first_out", a_data, 32'h3F80_0000);
        tick();
        a_v = 0; a_r = 1;
        repeat (3) tick();

        // Ordering / FWFT
        a_r = 1; a_v = 1; a_d = 32'h3F80_0000;
        tick();
        chk("t2_w0", a_data, 32'h3F80_0000); chk("t2_c0", 32'(a_count), 1);
        a_d = 32'h4000_0000;
        tick();
        chk("t2_w1", a_data, 32'h4000_0000); chk("t2_c1", 32'(a_count), 1);
        a_d = 32'h4040_0000;
        tick();
        chk("t2_w2", a_data, 32'h4040_0000); chk("t2_c2", 32'(a_count), 1);
        a_v = 0;
        tick();
        chk("t2_empty", 32'(a_valid), 0);

        // Stall threshold
        a_r = 0; a_v = 1;
        for (int i = 0; i < 25; i++) begin a_d = 32'hB000_0000 + 32'(i); tick(); end
        chk("t3_count20", 32'(a_count), 20);
        chk("t3_stall",   32'(a_stall), 1);
        a_r = 1;
        tick();
        chk("t3_count19", 32'(a_count), 19);
        chk("t3_unstall", 32'(a_stall), 0);
        a_r = 0;
        tick();
        a_v = 0; a_r = 1;
        repeat (25) tick();

        // Held valid with hold
        a_r = 0; a_v = 1; a_h = 1; a_d = 32'hC0DE_0001;
        repeat (4) tick();
        a_h = 0;
        tick();
        a_v = 0;
        tick();
        chk("t4_one_word", 32'(a_count), 1);
        a_r = 1;
        repeat (2) tick();

        // Full + simultaneous on the SLACK=0 instance
        b_r = 0; b_v = 1;
        for (int i = 0; i < DEPTH; i++) begin b_d = 32'hD000_0000 + 32'(i); tick(); end
        chk("t5_full",  32'(b_count), 32);
        chk("t5_ovf0",  32'(b_ovf), 0);
        b_r = 1; b_d = 32'hD000_0100;
        tick();
        chk("t5_pp_count", 32'(b_count), 32);
        chk("t5_pp_ovf",   32'(b_ovf), 0);
        b_r = 0; b_d = 32'hD000_0200;
        tick();
        chk("t5_ovf1", 32'(b_ovf), 1);
        b_v = 0;
        repeat (3) tick();
        chk("t5_ovf_sticky", 32'(b_ovf), 1);
        b_r = 1;
        repeat (34) tick();

        // Random soak with a latency-10 core model
        for (int i = 0; i < 10; i++) begin pv[i] = 0; pd[i] = '0; end
        p0 = pushes_a;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clock);
            st = a_stall | a_h;
            @(posedge clock);
            #1;
            if (!st) begin
                for (int i = 9; i > 0; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; end
                pv[0] = ($urandom_range(0, 99) < 70);
                pd[0] = 32'h5000_0000 + 32'(seq);
                seq++;
            end
            a_v = pv[9]; a_d = pd[9];
            a_r = ($urandom_range(0, 99) < 30);
            a_h = ($urandom_range(0, 99) < 10);
        end
        a_v = 0; a_h = 0; a_r = 1;
        repeat (40) tick();
        chk("t6_wraps", 32'((pushes_a - p0) >= 4 * DEPTH), 1);
        chk("t6_no_ovf", 32'(a_ovf), 0);
        chk("t6_drained", 32'(a_count), 0);

        @(negedge clock);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_proc_outbuf

`default_nettype wire
